// File: rtl/btn_pkg.sv
// Shared types and constants for the button scan controller.
package btn_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam int unsigned DEF_N_BTN      = 4;
  localparam int unsigned DEF_TICK_DIV   = 100000;
  localparam int unsigned DEF_STABLE_CNT = 4;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned BTN_IDX_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module tick_prescaler
  import btn_pkg::*;
#(
  parameter int unsigned DIV = DEF_TICK_DIV
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick = (count_q == LAST);

endmodule

// File: rtl/button_scan_controller.sv
// Round-robin debounce of N_BTN buttons with a queued press-event handshake.
// Optional release events are enabled with `define BTN_RELEASE_EVT_EN.
module button_scan_controller
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = DEF_N_BTN,
  parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
  parameter int unsigned STABLE_CNT = DEF_STABLE_CNT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_BTN-1:0]              btn_in,
  output logic [N_BTN-1:0]              btn_level,
  output logic                          press_valid,
  output logic [BTN_IDX_W(N_BTN)-1:0]   press_id,
  input  logic                          press_ready,
`ifdef BTN_RELEASE_EVT_EN
  output logic                          press_release,
`endif
  output logic                          overflow
);

  localparam int unsigned IW = BTN_IDX_W(N_BTN);
  localparam int unsigned CW = $clog2(STABLE_CNT);
`ifdef BTN_RELEASE_EVT_EN
  localparam int unsigned NSLOT = 2 * N_BTN;
`else
  localparam int unsigned NSLOT = N_BTN;
`endif
  localparam int unsigned SW = BTN_IDX_W(NSLOT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BTN - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NSLOT - 1);

  if (N_BTN < 2) begin : g_bad_n_btn
    $error("N_BTN must be at least 2");
  end
  if (TICK_DIV <= N_BTN + 1) begin : g_bad_tick_div
    $error("TICK_DIV must exceed N_BTN+1");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > 255) begin : g_bad_stable_cnt
    $error("STABLE_CNT must be in 2..255");
  end

  logic              tick;
  logic [N_BTN-1:0]  sync1_q, sync2_q, level_q;
  logic [CW-1:0]     cnt_q [N_BTN];
  scan_state_e       state_q;
  logic [IW-1:0]     idx_q;
  logic [NSLOT-1:0]  pending_q;
  logic [SW-1:0]     rr_q, slot_q;
  logic              valid_q, overflow_q;

  logic              cur_sync, cur_level, differ, flip, accept, sel_any;
  logic [CW-1:0]     cur_cnt;
  logic [NSLOT-1:0]  set_mask, acc_mask, pend_kept;
  logic [SW-1:0]     rr_next, sel_slot;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Shared compare/count datapath for the button under scan.
  always_comb begin
    cur_sync  = sync2_q[idx_q];
    cur_level = level_q[idx_q];
    cur_cnt   = cnt_q[idx_q];
    differ    = (state_q == ST_SCAN) && (cur_sync != cur_level);
    flip      = differ && (cur_cnt == CNT_LAST);
    set_mask  = '0;
    if (flip && cur_sync) begin
      set_mask[SW'(idx_q)] = 1'b1;
    end
`ifdef BTN_RELEASE_EVT_EN
    if (flip && !cur_sync) begin
      set_mask[SW'(N_BTN) + SW'(idx_q)] = 1'b1;
    end
`endif
    accept   = valid_q && press_ready;
    acc_mask = '0;
    if (accept) begin
      acc_mask[slot_q] = 1'b1;
    end
    pend_kept = pending_q & ~acc_mask;
    rr_next   = rr_q;
    if (accept) begin
      rr_next = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  // Round-robin pick over the slots still pending after this cycle's accept.
  always_comb begin
    int s;
    s        = 0;
    sel_any  = 1'b0;
    sel_slot = rr_next;
    for (int k = 0; k < int'(NSLOT); k++) begin
      s = int'(rr_next) + k;
      if (s >= int'(NSLOT)) begin
        s = s - int'(NSLOT);
      end
      if (!sel_any && pend_kept[s[SW-1:0]]) begin
        sel_any  = 1'b1;
        sel_slot = s[SW-1:0];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      level_q    <= '0;
      for (int i = 0; i < int'(N_BTN); i++) begin
        cnt_q[i] <= '0;
      end
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      pending_q  <= '0;
      rr_q       <= '0;
      slot_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_SCAN;
            idx_q   <= '0;
          end
        end
        ST_SCAN: begin
          if (!differ) begin
            cnt_q[idx_q] <= '0;
          end else if (flip) begin
            level_q[idx_q] <= cur_sync;
            cnt_q[idx_q]   <= '0;
          end else begin
            cnt_q[idx_q] <= cur_cnt + 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
      endcase
      // An accepted slot re-armed in the same cycle is not a loss.
      pending_q <= pend_kept | set_mask;
      if (|(set_mask & pend_kept)) begin
        overflow_q <= 1'b1;
      end
      rr_q <= rr_next;
      // Hold the presented event until the consumer takes it.
      if (!(valid_q && !press_ready)) begin
        valid_q <= sel_any;
        if (sel_any) begin
          slot_q <= sel_slot;
        end
      end
    end
  end

  assign btn_level   = level_q;
  assign press_valid = valid_q;
  assign overflow    = overflow_q;
`ifdef BTN_RELEASE_EVT_EN
  assign press_release = (slot_q >= SW'(N_BTN));
  assign press_id      = press_release ? IW'(slot_q - SW'(N_BTN)) : IW'(slot_q);
`else
  assign press_id      = slot_q;
`endif

  no_tick_in_scan: assert property (@(posedge clock) disable iff (reset)
    !(tick && state_q == ST_SCAN));

  id_stable_while_stalled: assert property (@(posedge clock) disable iff (reset)
    (valid_q && !press_ready) |=> (valid_q && $stable(slot_q)));

endmodule

// File: tb/tb_button_scan_controller.sv
// Self-checking bench for button_scan_controller (N_BTN=4, TICK_DIV=8, STABLE_CNT=3).
module tb_button_scan_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_in = '0;
  logic [3:0] btn_level;
  logic       press_valid;
  logic [1:0] press_id;
  logic       press_ready = 1'b0;
  logic       overflow;
`ifdef BTN_RELEASE_EVT_EN
  logic       press_release;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_q[$];

  always #5 clock = ~clock;

  button_scan_controller #(
    .N_BTN      (4),
    .TICK_DIV   (8),
    .STABLE_CNT (3)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_valid   (press_valid),
    .press_id      (press_id),
    .press_ready   (press_ready),
`ifdef BTN_RELEASE_EVT_EN
    .press_release (press_release),
`endif
    .overflow      (overflow)
  );

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted handshake must match the oldest expected id.
  always @(negedge clock) begin
    if (!reset && press_valid && press_ready) begin
      check_eq("sb_event_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check_eq("sb_press_id", press_id, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] btns);
    reset       = 1'b1;
    btn_in      = btns;
    press_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic wait_level(input logic [1:0] i, input logic v, input string tag);
    int n = 0;
    while (btn_level[i] !== v && n < 200) begin
      cyc(1);
      n++;
    end
    check_eq(tag, btn_level[i], v);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (press_valid !== 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    check_eq(tag, press_valid, 1);
  endtask

  initial begin
    // Reset values
    #1;
    check_eq("rst_level", btn_level, 0);
    check_eq("rst_valid", press_valid, 0);
    check_eq("rst_overflow", overflow, 0);

    // Single press on button 2: level on edge 27, valid on edge 28
    do_reset(4'b0100);
    exp_q.push_back(2);
    cyc(26);
    check_eq("p2_level_before", btn_level, 4'b0000);
    cyc(1);
    check_eq("p2_level_rise", btn_level, 4'b0100);
    check_eq("p2_valid_lag", press_valid, 0);
    cyc(1);
    check_eq("p2_valid", press_valid, 1);
    check_eq("p2_id", press_id, 2);
    press_ready = 1'b1;
    cyc(1);
    press_ready = 1'b0;
    check_eq("p2_valid_cleared", press_valid, 0);
    check_eq("p2_sb_drained", exp_q.size(), 0);

    // Bounce on button 1 shorter than the stability window
    do_reset(4'b0000);
    for (int t = 0; t < 12; t++) begin
      btn_in[1] = ~btn_in[1];
      cyc(10);
      check_eq("bounce_level", btn_level, 4'b0000);
      check_eq("bounce_valid", press_valid, 0);
    end

    // Buttons 0 and 3 in the same tick, consumer stalled for 20 cycles
    do_reset(4'b1001);
    exp_q.push_back(0);
    exp_q.push_back(3);
    wait_valid("dual_valid");
    check_eq("dual_first_id", press_id, 0);
    cyc(20);
    check_eq("dual_level", btn_level, 4'b1001);
    check_eq("dual_hold_valid", press_valid, 1);
    check_eq("dual_hold_id", press_id, 0);
    press_ready = 1'b1;
    cyc(1);
    check_eq("dual_second_valid", press_valid, 1);
    check_eq("dual_second_id", press_id, 3);
    cyc(1);
    press_ready = 1'b0;
    check_eq("dual_valid_drop", press_valid, 0);
    check_eq("dual_overflow", overflow, 0);
    check_eq("dual_sb_drained", exp_q.size(), 0);

    // Press, release, press again on button 1 before the first is accepted
    do_reset(4'b0010);
    exp_q.push_back(1);
    wait_level(2'd1, 1'b1, "ovf_first_rise");
    check_eq("ovf_clear_after_first", overflow, 0);
    cyc(1);
    check_eq("ovf_valid", press_valid, 1);
    check_eq("ovf_id", press_id, 1);
    btn_in[1] = 1'b0;
    wait_level(2'd1, 1'b0, "ovf_release");
    check_eq("ovf_release_valid", press_valid, 1);
    btn_in[1] = 1'b1;
    wait_level(2'd1, 1'b1, "ovf_second_rise");
    check_eq("ovf_set", overflow, 1);
    press_ready = 1'b1;
    cyc(1);
    press_ready = 1'b0;
    check_eq("ovf_single_event", press_valid, 0);
    cyc(2);
    check_eq("ovf_no_second_event", press_valid, 0);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("ovf_sb_drained", exp_q.size(), 0);

    // Reset during a scan with button 0 two samples into its window
    do_reset(4'b0010);
    cyc(26);
    check_eq("mid_btn1_level", btn_level, 4'b0010);
    btn_in[0] = 1'b1;
    cyc(15);
    check_eq("mid_valid_pre", press_valid, 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_level", btn_level, 0);
    check_eq("mid_rst_valid", press_valid, 0);
    check_eq("mid_rst_id", press_id, 0);
    check_eq("mid_rst_overflow", overflow, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    cyc(24);
    check_eq("mid_full_window", btn_level, 4'b0000);
    cyc(1);
    check_eq("mid_btn0_rise", btn_level, 4'b0001);
    cyc(1);
    check_eq("mid_btn1_rise", btn_level, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
